// File: rtl/fpnew_issue_rob.sv
// FPNew client initiator: tags requests, issues through a register stage,
// and reorders out-of-order FPU results back into issue order.
module fpnew_issue_rob #(
  parameter int FLEN      = 64,
  parameter int TAG_WIDTH = 2,
  parameter int ID_WIDTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [3:0]             req_op_i,
  input  logic                   req_op_mod_i,
  input  logic [2:0]             req_rnd_i,
  input  logic [2:0]             req_fmt_i,
  input  logic [3*FLEN-1:0]      req_operands_i,
  input  logic [ID_WIDTH-1:0]    req_id_i,
  input  logic                   flush_i,
  output logic                   fpu_in_valid_o,
  input  logic                   fpu_in_ready_i,
  output logic [3*FLEN-1:0]      fpu_operands_o,
  output logic [3:0]             fpu_op_o,
  output logic                   fpu_op_mod_o,
  output logic [2:0]             fpu_rnd_mode_o,
  output logic [2:0]             fpu_src_fmt_o,
  output logic [2:0]             fpu_dst_fmt_o,
  output logic [TAG_WIDTH-1:0]   fpu_tag_o,
  output logic                   fpu_flush_o,
  input  logic                   fpu_out_valid_i,
  output logic                   fpu_out_ready_o,
  input  logic [FLEN-1:0]        fpu_result_i,
  input  logic [4:0]             fpu_status_i,
  input  logic [TAG_WIDTH-1:0]   fpu_tag_i,
  input  logic                   fpu_busy_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [FLEN-1:0]        resp_result_o,
  output logic [4:0]             resp_status_o,
  output logic [ID_WIDTH-1:0]    resp_id_o,
  output logic                   err_o,
  output logic                   busy_o
);

  localparam int DEPTH = 2 ** TAG_WIDTH;
  localparam int CW    = TAG_WIDTH + 1;

  logic [TAG_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 err_q, err_d;
  logic                 iss_valid_q, iss_valid_d;

  logic [3*FLEN-1:0]    iss_opnds_q;
  logic [3:0]           iss_op_q;
  logic                 iss_mod_q;
  logic [2:0]           iss_rnd_q;
  logic [2:0]           iss_fmt_q;
  logic [TAG_WIDTH-1:0] iss_tag_q;

  logic [DEPTH-1:0]     vld_q, done_q;
  logic [ID_WIDTH-1:0]  id_q  [DEPTH];
  logic [FLEN-1:0]      res_q [DEPTH];
  logic [4:0]           st_q  [DEPTH];

  logic accept, retire, res_hit, res_miss;

  assign req_ready_o = (count_q < CW'(DEPTH))
                    && (!iss_valid_q || fpu_in_ready_i)
                    && !flush_i;
  assign accept = req_valid_i && req_ready_o;

  assign resp_valid_o  = vld_q[head_q] && done_q[head_q];
  assign resp_result_o = res_q[head_q];
  assign resp_status_o = st_q[head_q];
  assign resp_id_o     = id_q[head_q];
  assign retire = resp_valid_o && resp_ready_i;

  assign res_hit  = fpu_out_valid_i && vld_q[fpu_tag_i]
                 && !done_q[fpu_tag_i];
  assign res_miss = fpu_out_valid_i && !res_hit;

  assign fpu_in_valid_o  = iss_valid_q;
  assign fpu_operands_o  = iss_opnds_q;
  assign fpu_op_o        = iss_op_q;
  assign fpu_op_mod_o    = iss_mod_q;
  assign fpu_rnd_mode_o  = iss_rnd_q;
  assign fpu_src_fmt_o   = iss_fmt_q;
  assign fpu_dst_fmt_o   = iss_fmt_q;
  assign fpu_tag_o       = iss_tag_q;
  assign fpu_flush_o     = flush_i;
  assign fpu_out_ready_o = 1'b1;

  assign err_o  = err_q;
  assign busy_o = (count_q != '0) || iss_valid_q || fpu_busy_i;

  always_comb begin
    head_d      = head_q + TAG_WIDTH'(retire);
    tail_d      = tail_q + TAG_WIDTH'(accept);
    count_d     = count_q + CW'(accept) - CW'(retire);
    err_d       = err_q | res_miss;
    iss_valid_d = iss_valid_q;
    if (accept) begin
      iss_valid_d = 1'b1;
    end else if (fpu_in_ready_i) begin
      iss_valid_d = 1'b0;
    end
    // Flush wins over everything, including a stray result this cycle
    if (flush_i) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      err_d       = 1'b0;
      iss_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_opnds_q <= '0;
      iss_op_q    <= '0;
      iss_mod_q   <= 1'b0;
      iss_rnd_q   <= '0;
      iss_fmt_q   <= '0;
      iss_tag_q   <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      err_q       <= err_d;
      iss_valid_q <= iss_valid_d;
      if (accept) begin
        iss_opnds_q <= req_operands_i;
        iss_op_q    <= req_op_i;
        iss_mod_q   <= req_op_mod_i;
        iss_rnd_q   <= req_rnd_i;
        iss_fmt_q   <= req_fmt_i;
        iss_tag_q   <= tail_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= '0;
      done_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]  <= '0;
        res_q[i] <= '0;
        st_q[i]  <= '0;
      end
    end else if (flush_i) begin
      vld_q  <= '0;
      done_q <= '0;
    end else begin
      if (res_hit) begin
        done_q[fpu_tag_i] <= 1'b1;
        res_q[fpu_tag_i]  <= fpu_result_i;
        st_q[fpu_tag_i]   <= fpu_status_i;
      end
      if (retire) begin
        vld_q[head_q]  <= 1'b0;
        done_q[head_q] <= 1'b0;
      end
      if (accept) begin
        vld_q[tail_q]  <= 1'b1;
        done_q[tail_q] <= 1'b0;
        id_q[tail_q]   <= req_id_i;
      end
    end
  end

endmodule

// File: doc/fpnew_issue_rob.md
Name: fpnew_issue_rob

Overview:
- Client-side initiator for the FPNew blackbox handshake: accepts FP operation requests, assigns tags, and issues them to the FPU through a registered issue stage.
- Collects results, which may return out of order on the tag, into a tag-indexed reorder buffer.
- Returns responses to the client in issue order, each carrying the client ID.
- Sits between an accelerator core's FP command stream and the FPNew blackbox instance.

Parameters:
- FLEN, 64: operand and result width.
- TAG_WIDTH, 2: FPU tag width; ROB depth is DEPTH = 2**TAG_WIDTH.
- ID_WIDTH, 4: client transaction ID width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  client request valid
- req_ready_o  out  1  client request ready
- req_op_i  in  4  fpnew operation_e
- req_op_mod_i  in  1  operation modifier
- req_rnd_i  in  3  roundmode_e
- req_fmt_i  in  3  fp_format_e, driven to both src and dst fmt
- req_operands_i  in  3*FLEN  operands {c,b,a}
- req_id_i  in  ID_WIDTH  client ID
- flush_i  in  1  kill all outstanding work
- fpu_in_valid_o  out  1  FPU issue valid
- fpu_in_ready_i  in  1  FPU issue ready
- fpu_operands_o  out  3*FLEN  registered operands
- fpu_op_o  out  4  registered operation
- fpu_op_mod_o  out  1  registered modifier
- fpu_rnd_mode_o  out  3  registered rounding mode
- fpu_src_fmt_o  out  3  registered format
- fpu_dst_fmt_o  out  3  registered format
- fpu_tag_o  out  TAG_WIDTH  registered tag
- fpu_flush_o  out  1  equals flush_i (combinational)
- fpu_out_valid_i  in  1  FPU result valid
- fpu_out_ready_o  out  1  constant 1
- fpu_result_i  in  FLEN  FPU result
- fpu_status_i  in  5  status flags {NV,DZ,OF,UF,NX}
- fpu_tag_i  in  TAG_WIDTH  result tag
- fpu_busy_i  in  1  FPU busy
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response ready
- resp_result_o  out  FLEN  response result
- resp_status_o  out  5  response status flags
- resp_id_o  out  ID_WIDTH  response client ID
- err_o  out  1  sticky: stray result seen
- busy_o  out  1  work in flight

Behaviour:
- Reset state:
  - Pointers, count, issue register, slot valid/done bits and err_o are cleared.
  - fpu_in_valid_o = 0, resp_valid_o = 0, busy_o = fpu_busy_i, req_ready_o = !flush_i.
  - Reset asserted mid-operation discards all state immediately.
- ROB state: head and tail pointers (TAG_WIDTH bits, wrap modulo DEPTH) and count (0..DEPTH). Each slot holds valid, done, id, result and status.
- Request acceptance:
  - req_ready_o = (count < DEPTH) && (!iss_valid || fpu_in_ready_i) && !flush_i.
  - On req_valid_i && req_ready_o: the fields are loaded into the issue register with tag = tail; slot[tail] gets valid=1, done=0, id=req_id_i; tail++ and count++.
- Issue stage:
  - fpu_in_valid_o = iss_valid, so the FPU sees the request one cycle after acceptance.
  - All fpu_* request outputs are held stable while fpu_in_valid_o && !fpu_in_ready_i.
  - iss_valid clears on handshake unless a new request loads in the same cycle.
- Result write:
  - A result is any cycle with fpu_out_valid_i = 1.
  - If slot[fpu_tag_i] has valid=1 and done=0, the slot stores result and status and sets done=1.
  - Otherwise the result is dropped and err_o is set. err_o stays set until reset or flush.
- Response:
  - resp_valid_o = slot[head].valid && slot[head].done; the resp_* outputs are taken from slot[head].
  - A result arriving for the head slot appears on resp_valid_o the next cycle, so the minimum FPU-result-to-response latency is 1 cycle.
  - On resp_valid_o && resp_ready_i: slot[head] is cleared, head++ and count--.
- Simultaneous events:
  - Acceptance and retire in the same cycle leave count unchanged.
  - The retire-freed slot is not reusable until the next cycle, because req_ready_o uses the pre-retire count.
  - A result may write a slot in the same cycle another slot retires.
- Full: count == DEPTH forces req_ready_o = 0. Empty: resp_valid_o = 0.
- Flush (flush_i = 1), in the same cycle:
  - fpu_flush_o = 1.
  - Issue register, all slots, head, tail, count and err_o are cleared.
  - Any result arriving that cycle is dropped without setting err_o.
  - No response is produced for flushed operations.
- busy_o = (count != 0) || iss_valid || fpu_busy_i.

Test Plan:
- Reset: assert rst_i mid-traffic -> same cycle fpu_in_valid_o = 0, resp_valid_o = 0, err_o = 0; after release with flush_i = 0, req_ready_o = 1.
- Single op: FADD request id=5 accepted at cycle 0 -> fpu_in_valid_o = 1, tag = 0 at cycle 1; FPU stub returns tag 0, result 0x4008000000000000 at cycle 4 -> resp_valid_o = 1 at cycle 5 with id = 5 and that result.
- Out of order: issue ids 1, 2, 3 (tags 0, 1, 2); results return on tags 2, 0, 1 -> responses come out with ids 1, 2, 3 in that order; the tag-2 result waits until tag 1 retires.
- Full and wrap: 4 ops outstanding with resp_ready_i = 0 -> req_ready_o = 0; retire one -> req_ready_o = 1 the next cycle and the new request gets tag 0.
- Backpressure: fpu_in_ready_i = 0 for 3 cycles -> fpu_* outputs stay stable and req_ready_o = 0 while iss_valid = 1.
- Flush and stray result:
  - Flush with 3 ops outstanding -> count = 0 and no responses; a later result on tag 1 sets err_o = 1.
  - A result on an unallocated tag without any flush also sets err_o = 1.
